// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage: NOP encoding, FSM state codes
// and the sequential PC step.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int unsigned IF_STATE_WIDTH = 2;
  localparam logic [IF_STATE_WIDTH-1:0] IF_FETCH = 2'd0;
  localparam logic [IF_STATE_WIDTH-1:0] IF_DRAIN = 2'd1;
  localparam logic [IF_STATE_WIDTH-1:0] IF_HOLD  = 2'd2;

  localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: {valid, instruction, pc} with flush-to-NOP, hold and load.
// Flush has priority over hold, which has priority over load.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  hold,
  input  logic [INST_WIDTH-1:0] load_instruction,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] instruction_q, instruction_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d       = valid_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    if (flush) begin
      valid_d       = 1'b0;
      instruction_d = INST_WIDTH'(NOP_INST);
    end else if (!hold && load) begin
      valid_d       = 1'b1;
      instruction_d = load_instruction;
      pc_d          = load_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      instruction_q <= INST_WIDTH'(NOP_INST);
      pc_q          <= RESET_PC;
    end else begin
      valid_q       <= valid_d;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
    end
  end

  assign valid       = valid_q;
  assign instruction = instruction_q;
  assign pc          = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack handshake, one-entry
// hold buffer for responses that land while ID is stalled, and the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  logic [IF_STATE_WIDTH-1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d, pc_req_q;
  logic [ADDR_WIDTH-1:0]     buf_pc_q;
  logic [INST_WIDTH-1:0]     buf_inst_q;
  logic [ADDR_WIDTH-1:0]     redirect_target, pc_seq;
  logic                      stall_eff, redirect_eff, buf_load, ifid_load;

  // A disabled CPU looks exactly like a stalled one and cannot be redirected.
  assign stall_eff       = stall | ~cpu_en;
  assign redirect_eff    = redirect_valid & cpu_en;
  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
  assign pc_seq          = pc_q + ADDR_WIDTH'(PC_INCREMENT);

  assign imem_req  = rst & (state_q != IF_HOLD);
  assign imem_addr = (state_q == IF_DRAIN) ? pc_req_q : pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_load = 1'b0;
    case (state_q)
      IF_FETCH: begin
        if (redirect_eff) begin
          pc_d    = redirect_target;
          state_d = imem_ack ? IF_FETCH : IF_DRAIN;
        end else if (imem_ack) begin
          pc_d = pc_seq;
          if (stall_eff) begin
            state_d  = IF_HOLD;
            buf_load = 1'b1;
          end
        end
      end
      IF_DRAIN: begin
        if (redirect_eff) pc_d = redirect_target;
        if (imem_ack) state_d = IF_FETCH;
      end
      IF_HOLD: begin
        if (redirect_eff) begin
          pc_d    = redirect_target;
          state_d = IF_FETCH;
        end else if (!stall_eff) begin
          state_d = IF_FETCH;
        end
      end
      default: state_d = IF_FETCH;
    endcase
  end

  // pc_req_q shadows the address of the request in flight so DRAIN can keep presenting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      pc_req_q   <= RESET_PC;
      buf_inst_q <= INST_WIDTH'(NOP_INST);
      buf_pc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == IF_FETCH) pc_req_q <= pc_q;
      if (buf_load) begin
        buf_inst_q <= imem_rdata;
        buf_pc_q   <= pc_q;
      end
    end
  end

  assign ifid_load = ((state_q == IF_FETCH) & imem_ack) | (state_q == IF_HOLD);

  if_id_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_if_id_register (
    .clk              (clk),
    .rst              (rst),
    .load             (ifid_load),
    .flush            (redirect_eff),
    .hold             (stall_eff),
    .load_instruction ((state_q == IF_HOLD) ? buf_inst_q : imem_rdata),
    .load_pc          ((state_q == IF_HOLD) ? buf_pc_q : pc_q),
    .valid            (if_valid),
    .instruction      (if_instruction),
    .pc               (if_pc)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized stall/redirect/enable
// traffic, scored against an in-order instruction stream model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, cpu_en, stall, redirect_valid, imem_req, imem_ack, if_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_instruction, if_pc;

  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  logic [31:0] exp_pc;
  int          delay_fixed = 0;
  int          delay_rand = 0;
  int          wait_left = 0;
  bit          loaded = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_en         (cpu_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    h = a * 32'h9E37_79B1;
    return h ^ 32'h0000_5A13;
  endfunction

  // Memory responder: each new request gets a latency, ack pulses when it runs out.
  task automatic drive_mem();
    if (imem_req) begin
      if (!loaded) begin
        wait_left = delay_fixed + int'($urandom_range(delay_rand, 0));
        loaded = 1'b1;
      end
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        loaded = 1'b0;
      end else begin
        imem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      imem_ack = 1'b0;
      loaded = 1'b0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit en);
    logic        pre_valid, pre_req, pre_ack, eff_st, eff_rd;
    logic [31:0] pre_pc, pre_inst, pre_addr;
    @(negedge clk);
    stall = st;
    redirect_valid = rd;
    redirect_pc = rpc;
    cpu_en = en;
    drive_mem();
    pre_valid = if_valid;
    pre_pc = if_pc;
    pre_inst = if_instruction;
    pre_req = imem_req;
    pre_ack = imem_ack;
    pre_addr = imem_addr;
    eff_st = st | ~en;
    eff_rd = rd & en;
    @(posedge clk);
    #1;
    if (eff_rd) begin
      check("flush_valid", 64'(if_valid), 64'd0);
      check("flush_nop", 64'(if_instruction), 64'(NOP));
      exp_pc = rpc & ~32'h3;
    end else if (eff_st) begin
      check("stall_hold_pc", {31'd0, if_valid, if_pc}, {31'd0, pre_valid, pre_pc});
      check("stall_hold_inst", 64'(if_instruction), 64'(pre_inst));
    end else if (if_valid && (!pre_valid || if_pc != pre_pc)) begin
      check("deliver_pc", 64'(if_pc), 64'(exp_pc));
      check("deliver_inst", 64'(if_instruction), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    if (pre_req && !pre_ack) check("addr_stable", {31'd0, imem_req, imem_addr}, {32'd1, pre_addr});
  endtask

  initial begin
    int rand_start;
    rst = 1'b0;
    cpu_en = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_inst", 64'(if_instruction), 64'(NOP));
    check("rst_pc", 64'(if_pc), 64'd0);
    rst = 1'b1;
    #1;
    check("rel_req", 64'(imem_req), 64'd1);
    check("rel_addr", 64'(imem_addr), 64'd0);
    exp_pc = 32'h0;

    // Zero-wait stream from reset
    cycle(0, 0, 0, 1);
    check("first_pc", 64'(if_pc), 64'd0);
    check("first_inst", 64'(if_instruction), 64'h0050_0093);
    check("second_addr", 64'(imem_addr), 64'h4);
    cycle(0, 0, 0, 1);
    check("second_inst", 64'(if_instruction), 64'h0010_0113);

    // Stall for 3 cycles while the 0x8 response lands
    cycle(1, 0, 0, 1);
    check("hold_req0", 64'(imem_req), 64'd0);
    cycle(1, 0, 0, 1);
    check("hold_req1", 64'(imem_req), 64'd0);
    cycle(1, 0, 0, 1);
    check("hold_pc", 64'(if_pc), 64'h4);
    cycle(0, 0, 0, 1);
    check("release_pc", 64'(if_pc), 64'h8);
    check("release_addr", 64'(imem_addr), 64'hC);

    // Redirect while 0xC waits on a 3-cycle ack
    delay_fixed = 3;
    cycle(0, 1, 32'h40, 1);
    delay_fixed = 0;
    check("drain_addr0", 64'(imem_addr), 64'hC);
    cycle(0, 0, 0, 1);
    check("drain_addr1", 64'(imem_addr), 64'hC);
    cycle(0, 0, 0, 1);
    check("drain_addr2", 64'(imem_addr), 64'hC);
    cycle(0, 0, 0, 1);
    check("target_addr", 64'(imem_addr), 64'h40);
    check("drain_valid", 64'(if_valid), 64'd0);
    cycle(0, 0, 0, 1);
    check("target_pc", {31'd0, if_valid, if_pc}, {32'd1, 32'h40});

    // Redirect and stall together with the hold buffer full
    cycle(1, 0, 0, 1);
    check("buf_full_req", 64'(imem_req), 64'd0);
    cycle(1, 1, 32'h83, 1);
    check("rs_addr", {31'd0, imem_req, imem_addr}, {32'd1, 32'h80});
    cycle(0, 0, 0, 1);
    check("rs_pc", {31'd0, if_valid, if_pc}, {32'd1, 32'h80});

    // cpu_en low for 4 cycles with an ignored redirect
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h200, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("en_hold_pc", {31'd0, if_valid, if_pc}, {32'd1, 32'h80});
    cycle(0, 0, 0, 1);
    check("en_resume0", 64'(if_pc), 64'h84);
    cycle(0, 0, 0, 1);
    check("en_resume1", 64'(if_pc), 64'h88);

    // PC wrap, with junk low bits on the target
    cycle(0, 1, 32'hFFFF_FFFB, 1);
    repeat (3) cycle(0, 0, 0, 1);
    check("wrap_pc", {31'd0, if_valid, if_pc}, {32'd1, 32'h0});

    // Reset mid-request, with an ack arriving while reset is held
    delay_fixed = 2;
    cycle(0, 0, 0, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req", 64'(imem_req), 64'd0);
    check("mid_rst_valid", 64'(if_valid), 64'd0);
    check("mid_rst_inst", 64'(if_instruction), 64'(NOP));
    check("mid_rst_addr", 64'(imem_addr), 64'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #2;
    check("rst_ack_ignored", 64'(if_valid), 64'd0);
    imem_ack = 1'b0;
    loaded = 1'b0;
    delay_fixed = 0;
    exp_pc = 32'h0;
    rst = 1'b1;
    #1;
    check("rerel_addr", {31'd0, imem_req, imem_addr}, {32'd1, 32'h0});
    cycle(0, 0, 0, 1);
    check("rerel_pc", {31'd0, if_valid, if_pc}, {32'd1, 32'h0});

    // Randomized traffic
    delay_rand = 3;
    rand_start = deliveries;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
            32'($urandom_range(1023, 0)), $urandom_range(9, 0) != 0);
    end
    check("progress", 64'((deliveries - rand_start) > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage plus IF/ID pipeline register, sitting directly upstream of the instruction decoder. It owns the program counter and issues one instruction-memory request at a time over a req/ack handshake. It presents `instruction` and its PC to ID through a registered IF/ID stage, with stall, branch-redirect flush and a one-entry hold buffer for responses that arrive while ID is stalled.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `ADDR_WIDTH`, default 32: PC and imem address width.
- `INST_WIDTH`, default 32: instruction width (`INST_WIDTH` in define.vh).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_en`  in  1  global enable; when 0, behaves exactly as `stall`=1 and ignores `redirect_valid`.
- `stall`  in  1  hazard unit: hold IF/ID contents.
- `redirect_valid`  in  1  EX: branch/jump taken.
- `redirect_pc`  in  ADDR_WIDTH  target; bits [1:0] forced to 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  ADDR_WIDTH  word-aligned fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  one-cycle pulse; may occur in the same cycle `imem_req` rises.
- `imem_rdata`  in  INST_WIDTH  valid only when `imem_ack`=1.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `if_instruction`  out  INST_WIDTH  to the decoder `instruction` input.
- `if_pc`  out  ADDR_WIDTH  PC of `if_instruction`.

## Operation
- States:
  - FETCH: `imem_req`=1, addr = `pc`.
  - DRAIN: `imem_req`=1, addr = stale `pc_req`, response discarded.
  - HOLD: `imem_req`=0, hold buffer full.
- Reset values:
  - state = FETCH, `pc` = `pc_req` = RESET_PC.
  - `imem_req` = 0 while `rst`=0; it asserts in the first cycle after release.
  - `if_valid` = 0, `if_instruction` = 32'h0000_0013 (NOP), `if_pc` = RESET_PC, hold buffer empty.
- FETCH with ack, no stall, no redirect: IF/ID <= {rdata, pc}, `if_valid` <= 1, `pc` <= pc+4 (mod 2^ADDR_WIDTH), stay in FETCH.
- FETCH with ack and stall: IF/ID holds; buffer <= {rdata, pc}; `pc` <= pc+4; go to HOLD.
- HOLD with stall released: IF/ID <= buffer, buffer empties; go to FETCH.
- FETCH with no ack: address held, IF/ID unaffected except by stall/redirect.
- Redirect (priority over stall):
  - IF/ID <= NOP, `if_valid` <= 0, buffer cleared, `pc` <= redirect_pc.
  - If a request is outstanding and `imem_ack`=0 this cycle: go to DRAIN, with `pc_req` keeping the old address.
  - If ack arrives in the redirect cycle: rdata is discarded and the state is FETCH.
  - From HOLD: go to FETCH.
- DRAIN: on ack, discard rdata and go to FETCH (new `pc`). A further redirect during DRAIN only updates `pc`.
- Stall with IF/ID valid and no ack: all registers hold.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. IF/ID updates on the edge ending the ack cycle, so latency is 1 cycle from ack.
- Redirect to first valid target at ID: redirect edge, then request for the target, then ack; `if_valid` rises on the following edge. Minimum is 2 cycles with zero-wait memory.
- Ack during DRAIN costs one extra cycle before the target request.
- `if_valid` never stays 1 across a redirect edge.
- At most one outstanding request; `imem_addr` never changes while req=1 and ack=0.
- Reset asserted mid-request: everything returns to reset values asynchronously. An ack arriving during reset is ignored.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Structure
- define.vh gains:
  - `NOP_INST` (32'h0000_0013).
  - `IF_STATE_WIDTH` (2) and `IF_FETCH`/`IF_DRAIN`/`IF_HOLD` encodings.
  - `PC_INCREMENT` (4).
- Sub-module `if_id_register`: holds {valid, instruction, pc}, with load, flush-to-NOP and hold controls plus async active-low reset. The FSM, PC and hold buffer stay in the top.

## Test plan
- Reset release with zero-wait memory returning 0x00500093, 0x00100113 → `imem_addr` 0x0, then 0x4; `if_instruction` = 0x00500093 with `if_pc` = 0 one cycle after the first ack; NOP/`if_valid`=0 before that.
- Stall held for 3 cycles while ack at PC 0x8 arrives → IF/ID keeps PC 0x4, `imem_req`=0 for 2 cycles, then PC 0x8 is delivered on stall release with no instruction lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x40 while the request at 0xC is waiting for a delayed ack (3 cycles) → `imem_addr` stays 0xC until ack, that data is discarded, next request is 0x40, first valid `if_pc` = 0x40.
- Redirect and stall in the same cycle with the hold buffer full → `if_valid`=0, buffer empty, next fetch from the target.
- `cpu_en`=0 for 4 cycles mid-stream with a `redirect_valid` pulse → no state change, redirect ignored, stream resumes at the next sequential PC.
- `rst` pulsed low during an outstanding request → outputs return to reset values immediately; the first request after release is at RESET_PC.
